// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a writable branch-target table.
//
// Runs a three-state control machine (IDLE / RUN / HALTED) that advances the
// program counter by one per cycle while running. A decoded, taken branch
// redirects pc to an entry of a 32-deep target table. Stall holds pc, and
// halt parks the sequencer until the next start.
//
// Ports
//   clk      in   single clock, all state on rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin execution from START_ADDR (IDLE or HALTED only)
//   halt     in   decoded halt instruction
//   stall    in   hold pc this cycle
//   br_en    in   decoded branch instruction
//   br_cond  in   branch condition true
//   br_idx   in   branch-target table read index (combinational read)
//   cfg_we   in   table write strobe
//   cfg_idx  in   table write index
//   cfg_tgt  in   table write data
//   pc       out  current instruction address
//   busy     out  high while running
//   done     out  high while halted
module pc_sequencer #(
  parameter int unsigned     PC_W       = 16,
  parameter int unsigned     TGT_W      = 8,
  parameter logic [PC_W-1:0] START_ADDR = {PC_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             stall,
  input  logic             br_en,
  input  logic             br_cond,
  input  logic [4:0]       br_idx,
  input  logic             cfg_we,
  input  logic [4:0]       cfg_idx,
  input  logic [TGT_W-1:0] cfg_tgt,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TBL_DEPTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [PC_W-1:0]  pc_r;
  logic [PC_W-1:0]  pc_nxt_s;
  logic [PC_W-1:0]  br_tgt_s;
  logic             busy_r;
  logic             done_r;
  logic [TGT_W-1:0] tbl_r [TBL_DEPTH];

  // The read sees the table contents before this edge's write lands, so a
  // same-cycle write to the branch index never affects the current branch.
  assign br_tgt_s = PC_W'(tbl_r[br_idx]);

  // Branch-target table: cleared by reset, written by cfg_we in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        tbl_r[i] <= {TGT_W{1'b0}};
      end
    end else if (cfg_we) begin
      tbl_r[cfg_idx] <= cfg_tgt;
    end
  end

  // Next-state and next-pc selection; in RUN halt outranks stall outranks branch.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          pc_nxt_s    = START_ADDR;
        end else begin
          state_nxt_s = state_r;
          pc_nxt_s    = pc_r;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_nxt_s = ST_HALTED;
          pc_nxt_s    = pc_r;
        end else if (stall) begin
          state_nxt_s = ST_RUN;
          pc_nxt_s    = pc_r;
        end else if (br_en && br_cond) begin
          state_nxt_s = ST_RUN;
          pc_nxt_s    = br_tgt_s;
        end else begin
          // Natural wrap from all-ones back to zero.
          state_nxt_s = ST_RUN;
          pc_nxt_s    = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean idle state.
        state_nxt_s = ST_IDLE;
        pc_nxt_s    = START_ADDR;
      end
    endcase
  end

  // State, pc and status flags; busy/done are registered next-state decodes
  // so the outputs carry no combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pc_r    <= START_ADDR;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_HALTED);
    end
  end

  assign pc   = pc_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer.
// Each clock edge the reference model advances and pushes the expected
// {pc, busy, done}; a negedge monitor pops and compares against the DUT.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        stall;
  logic        br_en;
  logic        br_cond;
  logic [4:0]  br_idx;
  logic        cfg_we;
  logic [4:0]  cfg_idx;
  logic [7:0]  cfg_tgt;
  logic [15:0] pc;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  typedef struct packed {
    logic [15:0] pc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: running/halted flags, integer pc, integer table.
  int m_pc;
  bit m_run;
  bit m_halted;
  int m_tbl[32];

  pc_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .halt    (halt),
    .stall   (stall),
    .br_en   (br_en),
    .br_cond (br_cond),
    .br_idx  (br_idx),
    .cfg_we  (cfg_we),
    .cfg_idx (cfg_idx),
    .cfg_tgt (cfg_tgt),
    .pc      (pc),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_pc     = 0;
    m_run    = 1'b0;
    m_halted = 1'b0;
    foreach (m_tbl[i]) m_tbl[i] = 0;
  endfunction

  // One clock edge of the specified behaviour, then queue the expectation.
  function automatic void model_step();
    int   tgt;
    exp_t e;
    if (!rst_n) begin
      model_reset();
    end else begin
      tgt = m_tbl[br_idx];
      if (m_run) begin
        if (halt) begin
          m_run    = 1'b0;
          m_halted = 1'b1;
        end else if (stall) begin
          m_pc = m_pc;
        end else if (br_en && br_cond) begin
          m_pc = tgt;
        end else begin
          m_pc = (m_pc + 1) % 65536;
        end
      end else if (start) begin
        m_run    = 1'b1;
        m_halted = 1'b0;
        m_pc     = 0;
      end
      if (cfg_we) m_tbl[cfg_idx] = int'(cfg_tgt);
    end
    e.pc   = 16'(m_pc);
    e.busy = m_run;
    e.done = m_halted;
    exp_q.push_back(e);
  endfunction

  // Immediate comparison against the model (used for asynchronous reset).
  task automatic check_now(input string name);
    tests++;
    if (pc !== 16'(m_pc) || busy !== m_run || done !== m_halted) begin
      fails++;
      $display("FAIL %s: got pc=%h busy=%b done=%b, expected pc=%h busy=%b done=%b",
               name, pc, busy, done, 16'(m_pc), m_run, m_halted);
    end
  endtask

  task automatic step(input bit s, input bit h, input bit sl, input bit be,
                      input bit bc, input int bi, input bit we, input int wi,
                      input int wt);
    start   = s;
    halt    = h;
    stall   = sl;
    br_en   = be;
    br_cond = bc;
    br_idx  = 5'(bi);
    cfg_we  = we;
    cfg_idx = 5'(wi);
    cfg_tgt = 8'(wt);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  // Reset asserted between edges, checked immediately, held across one edge
  // with a table write that must be ignored, then released.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_now("async_reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 4, 8'hAA);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      tests++;
      if (pc !== mon_e.pc || busy !== mon_e.busy || done !== mon_e.done) begin
        fails++;
        $display("FAIL cycle @%0t: got pc=%h busy=%b done=%b, expected pc=%h busy=%b done=%b",
                 $time, pc, busy, done, mon_e.pc, mon_e.busy, mon_e.done);
      end
    end
  end

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    halt    = 1'b0;
    stall   = 1'b0;
    br_en   = 1'b0;
    br_cond = 1'b0;
    br_idx  = 5'd0;
    cfg_we  = 1'b0;
    cfg_idx = 5'd0;
    cfg_tgt = 8'd0;
    model_reset();
    #1;
    check_now("reset_state");
    idle();
    idle();
    rst_n = 1'b1;

    // Start and count: pc 0,1,2,3.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    repeat (3) idle();
    // Table write idx4=0x27 (pc->4), then pc->5.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 4, 8'h27);
    idle();
    // Not-taken branch at pc=5 -> 6.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b0, 0, 0);
    // idx1=5 (pc->7), taken to 5, taken at pc=5 via idx4 -> 0x27.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1, 8'h05);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0, 0, 0);
    // Same-cycle write and branch: old 0x27 used, next branch sees 0x40.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b1, 4, 8'h40);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0, 0, 0);
    // Get to pc=9 through idx2.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 2, 8'h09);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0, 0, 0);
    // Stall beats taken branch; halt beats stall.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4, 1'b0, 0, 0);
    // HALTED ignores branch and halt, start restarts at 0.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    // start ignored in RUN.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);

    // Count up to 0xFFFF, then wrap to 0.
    for (int i = 0; i < 70000 && m_pc != 65535; i++) idle();
    idle();
    idle();

    // Reset mid-RUN; table must be cleared after restart.
    async_reset();
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    idle();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0, 0, 0);

    // Randomized phase.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
      end else begin
        step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 24) == 0),
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
             1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 255)));
      end
    end

    idle();
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have these parameters:
- PC_W, 16, program counter width
- TGT_W, 8, stored branch-target width, zero-extended to PC_W
- START_ADDR, 0, PC value loaded on reset and on start
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin execution from START_ADDR
- halt  in  1  decoded halt instruction
- stall  in  1  hold PC this cycle
- br_en  in  1  decoded branch instruction
- br_cond  in  1  branch condition true
- br_idx  in  5  branch-target table index
- cfg_we  in  1  table write strobe
- cfg_idx  in  5  table write index
- cfg_tgt  in  TGT_W  table write data
- pc  out  PC_W  current instruction address
- busy  out  1  high in RUN
- done  out  1  high in HALTED

Function
REQ-003 The block SHALL hold a 32-entry x TGT_W writable branch-target table; cfg_we writes cfg_tgt to entry cfg_idx at the clock edge, in any state.
REQ-004 Table reads SHALL be combinational from br_idx; a same-cycle write to the read index SHALL NOT affect that cycle's branch (read-before-write).
REQ-005 The FSM SHALL have states IDLE, RUN, HALTED; reset state IDLE.
REQ-006 IDLE: start=1 -> RUN with pc=START_ADDR; otherwise remain, pc held.
REQ-007 RUN, priority highest first: halt=1 -> HALTED, pc held; stall=1 -> pc held, br_en ignored; br_en=1 and br_cond=1 -> pc = zero-extended table[br_idx]; otherwise pc = pc+1.
REQ-008 Taken branch SHALL update pc on the next edge (latency 1, no bubble); not-taken branch SHALL behave as pc+1.
REQ-009 pc+1 SHALL wrap modulo 2^PC_W (all-ones -> 0) with no flag.
REQ-010 start SHALL be ignored in RUN.
REQ-011 HALTED: pc held; start=1 -> RUN with pc=START_ADDR; other inputs ignored.
REQ-012 halt and stall asserted together in RUN: halt wins, next state HALTED.
REQ-013 busy SHALL be 1 exactly when state=RUN; done SHALL be 1 exactly when state=HALTED; both registered-state decodes, no combinational path from inputs.
REQ-014 br_en, br_cond, br_idx SHALL be don't-care outside RUN.

Reset
REQ-015 rst_n=0 SHALL immediately, without clock, set state=IDLE, pc=START_ADDR, busy=0, done=0, all table entries=0.
REQ-016 Reset mid-RUN SHALL abandon execution; after release the block waits in IDLE for start.
REQ-017 cfg_we SHALL be ignored while rst_n=0.

Verification
REQ-018 The bench SHALL cover:
- Reset release, start pulse, 3 idle cycles -> pc 0,1,2,3; busy=1, done=0.
- cfg write idx 4=0x27, then at pc=5 br_en=1, br_cond=1, br_idx=4 -> next pc=0x0027; br_cond=0 -> next pc=6.
- Same cycle cfg_we idx 4=0x40 and taken branch idx 4 (old 0x27) -> pc=0x0027; next branch idx 4 -> pc=0x0040.
- At pc=9 stall=1 with taken branch -> pc stays 9; halt=1 and stall=1 -> HALTED, done=1, pc=9; start -> pc=0, busy=1.
- pc=0xFFFF, no branch -> pc=0x0000.
- rst_n low mid-RUN between edges -> pc=0, busy=0, table entries read 0 after restart.
